led_status_driver: RTL and testbench
====================================

Name: led_status_driver

Overview:
- Generates active-low drive patterns for the four status LEDs on the Mercury KX1 module (pins M17, L18, L17, K18).
- Replaces the fixed LED output stage as the block that feeds the LED pins.
- Per-LED mode select: off, steady on, slow blink or fast blink.
- Per-LED event input, pulse-stretched to a visible flash.
- All timing is derived from one prescaled tick, so all blinking LEDs stay phase-locked.

Parameters:
- N_LED, 4, number of LEDs driven.
- TICK_DIV, 100000, clk cycles per timebase tick (1 kHz at 100 MHz); must be >= 2.
- SLOW_TICKS, 500, ticks per half-period of slow blink; must be >= 1.
- FAST_TICKS, 125, ticks per half-period of fast blink; must be >= 1.
- STRETCH_TICKS, 50, ticks an event keeps its LED lit; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2*N_LED  per-LED mode; bits [2i+1:2i] belong to LED i.
- event_in  in  N_LED  per-LED event strobe, synchronous to clk, any width.
- bright  in  4  global brightness, 0..15 (used only with the optional feature).
- led_n  out  N_LED  LED drive, active low (0 = lit).
- tick_o  out  1  one-cycle timebase tick, for other status logic.

Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - led_n = all 1s (all LEDs dark); tick_o = 0.
  - Prescaler, slow/fast counters and stretch counters = 0.
  - slow_ph = fast_ph = 0 (dark phase).
- Release is synchronous: the first tick occurs TICK_DIV cycles after the first clk edge with rst_n high.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick_o is high for exactly one cycle, registered, in the cycle after the count equals TICK_DIV-1.
- Slow blink:
  - Counter advances on tick; on reaching SLOW_TICKS-1 it wraps and slow_ph toggles.
  - Full period = 2*SLOW_TICKS ticks.
- Fast blink: identical, using FAST_TICKS and fast_ph.
- Mode decode:
  - 00 = off.
  - 01 = on.
  - 10 = lit when slow_ph = 1.
  - 11 = lit when fast_ph = 1.
- Stretch, per LED:
  - event_in[i] high in any cycle loads stretch_cnt[i] = STRETCH_TICKS.
  - Otherwise the counter decrements on tick when nonzero, saturating at 0.
  - If an event and a tick occur in the same cycle, the load wins.
  - A held-high event keeps the counter reloaded.
- Lit equation: lit[i] = mode_lit[i] OR (stretch_cnt[i] != 0).
- Output register: led_n[i] = ~lit_final[i].
  - Latency is 1 clk from a change on mode or event_in to led_n.
- Mode changes mid-period do not reset the blink phases; the new mode takes the current shared phase.
- Counter widths: $clog2(max+1) of each limit. No arithmetic overflow is possible.

Optional Feature:
- Macro: LED_STATUS_PWM_EN.
- Defined:
  - A free-running 4-bit pwm_cnt increments every clk and wraps 15 -> 0.
  - lit_final[i] = lit[i] AND (pwm_cnt < bright).
  - bright = 0 keeps all LEDs dark; bright = 15 gives a 15/16 duty cycle.
  - pwm_cnt resets to 0.
- Undefined: lit_final = lit; bright is ignored and pwm_cnt is not built.

Decomposition:
- Package led_status_pkg holds:
  - mode localparams LED_OFF = 2'b00, LED_ON = 2'b01, LED_SLOW = 2'b10, LED_FAST = 2'b11;
  - the LED_IDLE_N = 1'b1 drive constant.
- One sub-module, led_pulse_stretch (load/decrement/saturate counter), instantiated N_LED times via generate.
- The prescaler and blink phases stay in the top level.

Test Plan:
(Sim parameters TICK_DIV=4, SLOW_TICKS=4, FAST_TICKS=1, STRETCH_TICKS=3.)
- Reset, then mode = 8'b00_00_01_01 -> led_n = 4'b1111 during reset; led_n = 4'b1100 one cycle after the first post-reset edge; tick_o pulses every 4 cycles.
- mode = all 10 -> all LEDs dark for 16 cycles, then lit for 16, repeating; all four led_n bits identical every cycle.
- mode = all 11 -> all LEDs toggle every 4 cycles; switching LED0 to 10 mid-run does not disturb LEDs 1-3.
- mode = 00, single-cycle event_in[2] -> led_n[2] = 0 from the next cycle until 3 ticks have elapsed, then 1.
  - A retrigger after 2 ticks extends the flash by 3 further ticks.
  - An event coincident with a tick loads 3, not 2.
- Assert rst_n low asynchronously mid-blink and mid-stretch -> led_n = 4'b1111 immediately, without waiting for a clk edge; after release, the blink restarts from the dark phase.
- With LED_STATUS_PWM_EN, mode = all 01:
  - bright = 4 -> each led_n low for 4 of every 16 cycles;
  - bright = 0 -> constant 4'b1111.

Source files
------------

// File: rtl/led_status_pkg.sv
// Shared constants for the status LED driver: per-LED mode encodings and the
// pin level that leaves an active-low LED dark.
package led_status_pkg;

   localparam logic [1:0] LED_OFF  = 2'b00;
   localparam logic [1:0] LED_ON   = 2'b01;
   localparam logic [1:0] LED_SLOW = 2'b10;
   localparam logic [1:0] LED_FAST = 2'b11;

   localparam logic LED_IDLE_N = 1'b1;

endpackage

// File: rtl/led_pulse_stretch.sv
// Stretches a short event strobe into a flash lasting STRETCH_TICKS timebase
// ticks; a new event reloads the counter, even when it lands on a tick.
module led_pulse_stretch #(
   parameter int STRETCH_TICKS = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic event_i,
   output logic active_o
);

   localparam int CNT_W = $clog2(STRETCH_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (event_i) begin
         cnt_d = CNT_LOAD;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The live strobe counts as active so the flash appears one clk after the event.
   assign active_o = event_i || (cnt_q != '0);

endmodule

// File: rtl/led_status_driver.sv
// Active-low status LED driver: per-LED off/on/slow/fast modes plus stretched
// event flashes, all phase-locked to one prescaled tick. LED_STATUS_PWM_EN adds brightness PWM.
module led_status_driver
   import led_status_pkg::*;
#(
   parameter int N_LED         = 4,
   parameter int TICK_DIV      = 100000,
   parameter int SLOW_TICKS    = 500,
   parameter int FAST_TICKS    = 125,
   parameter int STRETCH_TICKS = 50
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2*N_LED-1:0] mode,
   input  logic [N_LED-1:0]   event_in,
   input  logic [3:0]         bright,
   output logic [N_LED-1:0]   led_n,
   output logic               tick_o
);

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam int SLOW_W  = $clog2(SLOW_TICKS + 1);
   localparam int FAST_W  = $clog2(FAST_TICKS + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
   localparam logic [SLOW_W-1:0]  SLOW_LAST  = SLOW_W'(SLOW_TICKS - 1);
   localparam logic [SLOW_W-1:0]  SLOW_ONE   = SLOW_W'(1);
   localparam logic [FAST_W-1:0]  FAST_LAST  = FAST_W'(FAST_TICKS - 1);
   localparam logic [FAST_W-1:0]  FAST_ONE   = FAST_W'(1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               tick_q, tick_d;
   logic [SLOW_W-1:0]  slow_cnt_q, slow_cnt_d;
   logic [FAST_W-1:0]  fast_cnt_q, fast_cnt_d;
   logic               slow_ph_q, slow_ph_d;
   logic               fast_ph_q, fast_ph_d;
   logic [N_LED-1:0]   led_q, led_d;

   logic [N_LED-1:0]   mode_lit;
   logic [N_LED-1:0]   stretch_act;
   logic [N_LED-1:0]   lit;
   logic [N_LED-1:0]   lit_final;

   always_comb begin
      presc_d    = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_ONE;
      tick_d     = (presc_q == PRESC_LAST);
      slow_cnt_d = slow_cnt_q;
      slow_ph_d  = slow_ph_q;
      fast_cnt_d = fast_cnt_q;
      fast_ph_d  = fast_ph_q;
      if (tick_q) begin
         if (slow_cnt_q == SLOW_LAST) begin
            slow_cnt_d = '0;
            slow_ph_d  = ~slow_ph_q;
         end else begin
            slow_cnt_d = slow_cnt_q + SLOW_ONE;
         end
         if (fast_cnt_q == FAST_LAST) begin
            fast_cnt_d = '0;
            fast_ph_d  = ~fast_ph_q;
         end else begin
            fast_cnt_d = fast_cnt_q + FAST_ONE;
         end
      end
   end

   // Blink modes read the shared phases, so a mode change never re-phases an LED.
   always_comb begin
      mode_lit = '0;
      for (int i = 0; i < N_LED; i++) begin
         case (mode[2*i +: 2])
            LED_OFF:  mode_lit[i] = 1'b0;
            LED_ON:   mode_lit[i] = 1'b1;
            LED_SLOW: mode_lit[i] = slow_ph_q;
            LED_FAST: mode_lit[i] = fast_ph_q;
         endcase
      end
   end

   for (genvar g = 0; g < N_LED; g++) begin : g_stretch
      led_pulse_stretch #(
         .STRETCH_TICKS(STRETCH_TICKS)
      ) u_stretch (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick_i  (tick_q),
         .event_i (event_in[g]),
         .active_o(stretch_act[g])
      );
   end

   assign lit = mode_lit | stretch_act;

`ifdef LED_STATUS_PWM_EN
   logic [3:0] pwm_q, pwm_d;

   assign pwm_d = pwm_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= 4'd0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign lit_final = lit & {N_LED{pwm_q < bright}};
`else
   logic unused_bright;

   assign unused_bright = ^bright;
   assign lit_final     = lit;
`endif

   assign led_d = ~lit_final;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         tick_q     <= 1'b0;
         slow_cnt_q <= '0;
         fast_cnt_q <= '0;
         slow_ph_q  <= 1'b0;
         fast_ph_q  <= 1'b0;
         led_q      <= {N_LED{LED_IDLE_N}};
      end else begin
         presc_q    <= presc_d;
         tick_q     <= tick_d;
         slow_cnt_q <= slow_cnt_d;
         fast_cnt_q <= fast_cnt_d;
         slow_ph_q  <= slow_ph_d;
         fast_ph_q  <= fast_ph_d;
         led_q      <= led_d;
      end
   end

   assign led_n  = led_q;
   assign tick_o = tick_q;

endmodule

// File: tb/tb_led_status_driver.sv
// Directed bench for led_status_driver with a fast timebase (TICK_DIV=4,
// SLOW_TICKS=4, FAST_TICKS=1, STRETCH_TICKS=3); edge k counts clk edges after reset release.
module tb_led_status_driver;

   localparam int N_LED         = 4;
   localparam int TICK_DIV      = 4;
   localparam int SLOW_TICKS    = 4;
   localparam int FAST_TICKS    = 1;
   localparam int STRETCH_TICKS = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [7:0]       mode = 8'h00;
   logic [3:0]       event_in = 4'h0;
   logic [3:0]       bright = 4'h0;
   logic [3:0]       led_n;
   logic             tick_o;

   int total = 0;
   int bad   = 0;

   led_status_driver #(
      .N_LED        (N_LED),
      .TICK_DIV     (TICK_DIV),
      .SLOW_TICKS   (SLOW_TICKS),
      .FAST_TICKS   (FAST_TICKS),
      .STRETCH_TICKS(STRETCH_TICKS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode    (mode),
      .event_in(event_in),
      .bright  (bright),
      .led_n   (led_n),
      .tick_o  (tick_o)
   );

   always #5 clk = ~clk;

   // Slow phase goes high at edge 17 and shows on the pins at edge 18, then every 16 edges.
   function automatic bit slow_lit(input int k);
      return (k >= 18) && ((((k - 18) / 16) % 2) == 0);
   endfunction

   // Fast phase toggles on every consumed tick (edges 5, 9, ...), visible one edge later.
   function automatic bit fast_lit(input int k);
      return (k >= 6) && ((((k - 6) / 4) % 2) == 0);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [7:0] m);
      rst_n    = 1'b0;
      mode     = m;
      event_in = 4'h0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic exp_tick;
      rst_n    = 1'b0;
      mode     = 8'b00_00_01_01;
      event_in = 4'h0;
      #1;
      total++;
      if (led_n !== 4'b1111) begin
         bad++;
         $display("FAIL reset_led: led_n=%b expected %b", led_n, 4'b1111);
      end
      total++;
      if (tick_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_tick: tick_o=%b expected 0", tick_o);
      end
      for (int r = 0; r < 2; r++) begin
         step();
         total++;
         if (led_n !== 4'b1111) begin
            bad++;
            $display("FAIL reset_clocked r=%0d: led_n=%b expected %b", r, led_n, 4'b1111);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_tick = ((k % 4) == 0);
         total++;
         if (led_n !== 4'b1100) begin
            bad++;
            $display("FAIL on_mode k=%0d: led_n=%b expected %b", k, led_n, 4'b1100);
         end
         total++;
         if (tick_o !== exp_tick) begin
            bad++;
            $display("FAIL tick k=%0d: tick_o=%b expected %b", k, tick_o, exp_tick);
         end
      end
   endtask

   task automatic test_slow();
      logic [3:0] exp;
      do_reset(8'b10_10_10_10);
      for (int k = 1; k <= 50; k++) begin
         step();
         exp = slow_lit(k) ? 4'b0000 : 4'b1111;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL slow k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
      end
   endtask

   task automatic test_fast();
      logic [3:0] exp;
      do_reset(8'b11_11_11_11);
      for (int k = 1; k <= 20; k++) begin
         step();
         exp = fast_lit(k) ? 4'b0000 : 4'b1111;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL fast k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
      end
      mode = 8'b11_11_11_10;
      for (int k = 21; k <= 40; k++) begin
         step();
         exp[0]   = slow_lit(k) ? 1'b0 : 1'b1;
         exp[3:1] = fast_lit(k) ? 3'b000 : 3'b111;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL fast_mixed k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
      end
   endtask

   task automatic test_stretch();
      logic [3:0] exp;
      // Single event seen at edge 3; ticks consumed at edges 5, 9, 13.
      do_reset(8'h00);
      for (int k = 1; k <= 16; k++) begin
         step();
         exp = (k >= 3 && k <= 13) ? 4'b1011 : 4'b1111;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL stretch_single k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
         event_in = (k == 2) ? 4'b0100 : 4'b0000;
      end
      // Retrigger at edge 11 after two ticks; reload runs out at edge 21.
      do_reset(8'h00);
      for (int k = 1; k <= 24; k++) begin
         step();
         exp = (k >= 3 && k <= 21) ? 4'b1011 : 4'b1111;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL stretch_retrig k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
         event_in = (k == 2 || k == 10) ? 4'b0100 : 4'b0000;
      end
      // Event coincides with the tick consumed at edge 5: load 3, dark from edge 18.
      do_reset(8'h00);
      for (int k = 1; k <= 20; k++) begin
         step();
         exp = (k >= 5 && k <= 17) ? 4'b1011 : 4'b1111;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL stretch_on_tick k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
         event_in = (k == 4) ? 4'b0100 : 4'b0000;
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] exp;
      do_reset(8'b10_10_10_00);
      for (int k = 1; k <= 20; k++) begin
         step();
         exp[3:1] = slow_lit(k) ? 3'b000 : 3'b111;
         exp[0]   = (k >= 18) ? 1'b0 : 1'b1;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL pre_async k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
         event_in = (k == 17) ? 4'b0001 : 4'b0000;
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (led_n !== 4'b1111) begin
         bad++;
         $display("FAIL async_reset: led_n=%b expected %b", led_n, 4'b1111);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp[3:1] = slow_lit(k) ? 3'b000 : 3'b111;
         exp[0]   = 1'b1;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL post_async k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
      end
   endtask

`ifdef LED_STATUS_PWM_EN
   task automatic test_pwm();
      logic [3:0] exp;
      int         lows;
      bright = 4'd4;
      do_reset(8'b01_01_01_01);
      lows = 0;
      for (int k = 1; k <= 32; k++) begin
         step();
         exp = (((k - 1) % 16) < 4) ? 4'b0000 : 4'b1111;
         if (led_n[0] === 1'b0) lows++;
         total++;
         if (led_n !== exp) begin
            bad++;
            $display("FAIL pwm4 k=%0d: led_n=%b expected %b", k, led_n, exp);
         end
      end
      total++;
      if (lows != 8) begin
         bad++;
         $display("FAIL pwm4_duty: low cycles=%0d expected 8", lows);
      end
      bright = 4'd0;
      do_reset(8'b01_01_01_01);
      for (int k = 1; k <= 20; k++) begin
         step();
         total++;
         if (led_n !== 4'b1111) begin
            bad++;
            $display("FAIL pwm0 k=%0d: led_n=%b expected %b", k, led_n, 4'b1111);
         end
      end
   endtask
`endif

   initial begin
      #2;
`ifdef LED_STATUS_PWM_EN
      test_pwm();
`else
      bright = 4'd15;
      test_reset();
      test_slow();
      test_fast();
      test_stretch();
      test_async_reset();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
